// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a runtime-loadable pattern, length and overlap mode.
// It raises a registered one-cycle match pulse and keeps a saturating match counter.
module seq_detector_param #(
  parameter int                 MAX_LEN         = 8,
  parameter int                 CNT_W           = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 8'b0010_1011,
  parameter int                 DEFAULT_LEN     = 6,
  parameter bit                 DEFAULT_OVERLAP = 1'b1,
  localparam int                LEN_W           = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data_in,
  input  logic               valid_in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               data_out,
  output logic [LEN_W-1:0]   state,
  output logic [CNT_W-1:0]   match_count
);

  localparam int DEF_LEN_I = (DEFAULT_LEN < 1) ? 1 :
                             (DEFAULT_LEN > MAX_LEN) ? MAX_LEN : DEFAULT_LEN;
  localparam logic [LEN_W-1:0] DEF_LEN = LEN_W'(DEF_LEN_I);
  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [MAX_LEN-1:0] history;
  logic [MAX_LEN-1:0] act_pattern;
  logic [LEN_W-1:0]   act_len;
  logic               act_overlap;

  logic [MAX_LEN-1:0] shifted;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   state_inc;
  logic [LEN_W-1:0]   cfg_len_eff;
  logic               hit;

  // Handshake: valid_in is a pure qualifier with no backpressure; data_in is
  // consumed on every rising edge where valid_in=1, unless cfg_load=1 in that cycle.
  always_comb begin
    shifted   = {history[MAX_LEN-2:0], data_in};
    state_inc = (state >= act_len) ? act_len : state + LEN_W'(1);
    len_mask  = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(act_len));
    end
    hit = (((shifted ^ act_pattern) & len_mask) == '0) && (state_inc == act_len);
    if (cfg_len == '0)        cfg_len_eff = LEN_W'(1);
    else if (cfg_len > MAX_L) cfg_len_eff = MAX_L;
    else                      cfg_len_eff = cfg_len;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      history     <= '0;
      state       <= '0;
      data_out    <= 1'b0;
      match_count <= '0;
      act_pattern <= DEFAULT_PATTERN;
      act_len     <= DEF_LEN;
      act_overlap <= DEFAULT_OVERLAP;
    end else if (cfg_load) begin
      // The data bit sampled alongside a config load is dropped on purpose.
      act_pattern <= cfg_pattern;
      act_len     <= cfg_len_eff;
      act_overlap <= cfg_overlap;
      state       <= '0;
      data_out    <= 1'b0;
    end else if (valid_in) begin
      history  <= shifted;
      data_out <= hit;
      if (hit) begin
        state <= act_overlap ? act_len : '0;
        if (match_count != CNT_MAX) match_count <= match_count + CNT_W'(1);
      end else begin
        state <= state_inc;
      end
    end else begin
      data_out <= 1'b0;
    end
  end

endmodule
